// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiplier-sharing MAC scheduler.
package mac_pkg;

    localparam int OPSIZE_DEF = 8;
    localparam int ACCW_DEF   = 2 * OPSIZE_DEF + 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESULT
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/mac_sched.sv
// Time-shares one multi-cycle multiplier among NREQ requesters, accumulating a
// per-packet dot product and returning it tagged with the requester id.
module mac_sched
    import mac_pkg::*;
#(
    parameter int OPSIZE = OPSIZE_DEF,
    parameter int NREQ   = 2,
    parameter int ACCW   = 2 * OPSIZE + 4,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*OPSIZE-1:0] req_a,
    input  logic [NREQ*OPSIZE-1:0] req_b,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    output logic [ACCW-1:0]        res_data,
    output logic [IDW-1:0]         res_id,
    output logic                   res_ovf,
    input  logic                   res_ready,
    output logic                   mul_start,
    output logic [OPSIZE-1:0]      mul_a,
    output logic [OPSIZE-1:0]      mul_b,
    input  logic [2*OPSIZE-1:0]    mul_out,
    input  logic                   mul_ready,
    output logic                   busy
);

    sched_state_t        state_q, state_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [OPSIZE-1:0]   a_q, a_d;
    logic [OPSIZE-1:0]   b_q, b_d;
    logic                last_q, last_d;
    logic [ACCW-1:0]     acc_q, acc_d;
    logic                ovf_q, ovf_d;

    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_id;
    logic [ACCW:0]       sum;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Extra MSB of the sum is the carry out of the ACCW-bit accumulator.
    assign sum = {1'b0, acc_q} + {{(ACCW + 1 - 2 * OPSIZE){1'b0}}, mul_out};

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    id_d    = gnt_id;
                    ptr_d   = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (req_valid[id_q]) begin
                    a_d     = req_a[id_q*OPSIZE +: OPSIZE];
                    b_d     = req_b[id_q*OPSIZE +: OPSIZE];
                    last_d  = req_last[id_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!mul_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mul_ready) begin
                    acc_d   = sum[ACCW-1:0];
                    ovf_d   = ovf_q | sum[ACCW];
                    state_d = last_q ? RESULT : FETCH;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Accept depends only on the held grant and that requester's valid.
    always_comb begin
        req_ready = '0;
        if (state_q == FETCH) req_ready[id_q] = req_valid[id_q];
    end

    assign mul_start = (state_q == ISSUE);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign res_valid = (state_q == RESULT);
    assign res_data  = acc_q;
    assign res_id    = id_q;
    assign res_ovf   = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: multiplier model with 4-cycle busy, per-requester
// expected-result queues computed from whole-packet sums, directed and random packets.
module tb_mac_sched;

    localparam int OPSIZE = 8;
    localparam int NREQ   = 2;
    localparam int ACCW   = 16;
    localparam int IDW    = 1;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NREQ-1:0]        req_valid, req_last, req_ready;
    logic [NREQ*OPSIZE-1:0] req_a, req_b;
    logic                   res_valid, res_ovf, res_ready;
    logic [ACCW-1:0]        res_data;
    logic [IDW-1:0]         res_id;
    logic                   mul_start, busy;
    logic [OPSIZE-1:0]      mul_a, mul_b;
    logic [2*OPSIZE-1:0]    mul_out   = '0;
    logic                   mul_ready = 1'b1;

    logic              drv_v [NREQ];
    logic              drv_l [NREQ];
    logic [OPSIZE-1:0] drv_a [NREQ];
    logic [OPSIZE-1:0] drv_b [NREQ];

    int errors = 0;
    int checks = 0;
    int nstart = 0;

    logic [63:0]  exp_data [NREQ][$];
    bit           exp_ovf  [NREQ][$];
    int unsigned  id_log[$];
    logic [63:0]  data_log[$];
    bit           ovf_log[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_valid[g]                 = drv_v[g];
        assign req_last[g]                  = drv_l[g];
        assign req_a[g*OPSIZE +: OPSIZE]    = drv_a[g];
        assign req_b[g*OPSIZE +: OPSIZE]    = drv_b[g];
    end

    mac_sched #(
        .OPSIZE (OPSIZE),
        .NREQ   (NREQ),
        .ACCW   (ACCW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .mul_ready (mul_ready),
        .busy      (busy)
    );

    // Multiplier: goes busy the edge after start, product valid 4 edges later.
    int          mcnt = 0;
    logic [15:0] mprod = '0;
    always @(posedge clk) begin
        if (mul_start === 1'b1) begin
            mul_ready <= 1'b0;
            mcnt      <= 4;
            mprod     <= mul_a * mul_b;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mul_ready <= 1'b1;
                mul_out   <= mprod;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Result monitor: every accepted result is matched against its requester's queue.
    always @(negedge clk) begin : monitor
        logic [63:0] ed;
        bit          eo;
        if (rst_n && mul_start) nstart++;
        if (rst_n && res_valid && res_ready) begin
            id_log.push_back(int'(res_id));
            data_log.push_back(64'(res_data));
            ovf_log.push_back(res_ovf);
            if (exp_data[res_id].size() == 0) begin
                timeout_fail("unexpected_result");
            end else begin
                ed = exp_data[res_id].pop_front();
                eo = exp_ovf[res_id].pop_front();
                check("res_data", 64'(res_data), ed);
                check("res_ovf", 64'(res_ovf), 64'(eo));
            end
        end
    end

    task automatic send_pkt(input int id, input int unsigned av[$], input int unsigned bv[$],
                            input int gap);
        longint unsigned tot = 0;
        int              t;
        for (int i = 0; i < av.size(); i++) tot += longint'(av[i]) * bv[i];
        exp_data[id].push_back(64'(tot % (64'd1 << ACCW)));
        exp_ovf[id].push_back(tot >= (64'd1 << ACCW));
        for (int i = 0; i < av.size(); i++) begin
            if (i > 0 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            drv_v[id] = 1'b1;
            drv_a[id] = OPSIZE'(av[i]);
            drv_b[id] = OPSIZE'(bv[i]);
            drv_l[id] = (i == av.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (req_ready[id] === 1'b1) break;
                if (++t > 3000) begin
                    timeout_fail("req_accept");
                    break;
                end
            end
            @(posedge clk);
            #1;
            drv_v[id] = 1'b0;
            drv_l[id] = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_data[0].size() + exp_data[1].size()) != 0 || busy !== 1'b0) begin
            @(negedge clk);
            if (++t > 5000) begin
                timeout_fail("drain");
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned qa[$], qb[$], qc[$], qd[$];
        int          base, t, rand_done;
        logic [63:0] held;

        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            drv_v[i] = 1'b0; drv_l[i] = 1'b0; drv_a[i] = '0; drv_b[i] = '0;
        end

        // Reset values
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data",  64'(res_data),  64'd0);
        check("rst_res_id",    64'(res_id),    64'd0);
        check("rst_res_ovf",   64'(res_ovf),   64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_mul_a",     64'(mul_a),     64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        rst_n = 1'b1;

        // Two-pair packet from requester 0
        base = nstart;
        qa = '{3, 5}; qb = '{4, 6};
        send_pkt(0, qa, qb, 0);
        wait_drain();
        check("t1_starts", 64'(nstart - base), 64'd2);
        check("t1_data", data_log[data_log.size()-1], 64'd42);
        check("t1_id", 64'(id_log[id_log.size()-1]), 64'd0);

        // No requests: stay idle
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ready", 64'(req_ready), 64'd0);

        // Round-robin from a fresh pointer
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        base = id_log.size();
        qa = '{1}; qb = '{1};
        fork
            for (int p = 0; p < 3; p++) send_pkt(0, qa, qb, 0);
            for (int p = 0; p < 3; p++) send_pkt(1, qa, qb, 0);
        join
        wait_drain();
        check("t2_count", 64'(id_log.size() - base), 64'd6);
        for (int i = 0; i < 6; i++)
            if (base + i < id_log.size())
                check("t2_id_seq", 64'(id_log[base+i]), 64'(i % 2));

        // Wrap and sticky overflow, then a clean packet
        qa = '{255, 255}; qb = '{255, 255};
        send_pkt(1, qa, qb, 0);
        wait_drain();
        check("t3_data", data_log[data_log.size()-1], 64'd64514);
        check("t3_ovf", 64'(ovf_log[ovf_log.size()-1]), 64'd1);
        qa = '{1}; qb = '{1};
        send_pkt(1, qa, qb, 0);
        wait_drain();
        check("t3b_data", data_log[data_log.size()-1], 64'd1);
        check("t3b_ovf", 64'(ovf_log[ovf_log.size()-1]), 64'd0);

        // Back-pressured result stays stable, no operands accepted
        res_ready = 1'b0;
        qa = '{7}; qb = '{9};
        send_pkt(0, qa, qb, 0);
        t = 0;
        while (res_valid !== 1'b1) begin
            @(negedge clk);
            if (++t > 100) begin timeout_fail("t4_res_valid"); break; end
        end
        @(posedge clk); #1;
        drv_v[1] = 1'b1; drv_a[1] = 8'd2; drv_b[1] = 8'd2; drv_l[1] = 1'b1;
        held = 64'(res_data);
        check("t4_held_data", held, 64'd63);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_res_valid", 64'(res_valid), 64'd1);
            check("t4_stable_data", 64'(res_data), held);
            check("t4_stable_id", 64'(res_id), 64'd0);
            check("t4_req_ready", 64'(req_ready), 64'd0);
            check("t4_mul_a_hold", 64'(mul_a), 64'd7);
        end
        @(posedge clk); #1;
        drv_v[1] = 1'b0; drv_l[1] = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_busy_after", 64'(busy), 64'd0);
        wait_drain();

        // Asynchronous reset while waiting on the multiplier
        @(posedge clk); #1;
        drv_v[0] = 1'b1; drv_a[0] = 8'd5; drv_b[0] = 8'd5; drv_l[0] = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (req_ready[0] === 1'b1) break;
            if (++t > 100) begin timeout_fail("t5_accept"); break; end
        end
        @(posedge clk); #1 drv_v[0] = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (mul_ready === 1'b0) break;
            if (++t > 100) begin timeout_fail("t5_mul_busy"); break; end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_mul_a", 64'(mul_a), 64'd0);
        check("t5_mul_b", 64'(mul_b), 64'd0);
        check("t5_res_data", 64'(res_data), 64'd0);
        check("t5_mul_start", 64'(mul_start), 64'd0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b1;
        qa = '{2}; qb = '{2};
        send_pkt(0, qa, qb, 0);
        wait_drain();
        check("t5_data", data_log[data_log.size()-1], 64'd4);

        // Mid-packet stall in FETCH blocks the other requester
        base = id_log.size();
        qa = '{10, 20}; qb = '{10, 20};
        qc = '{1};      qd = '{1};
        fork
            send_pkt(0, qa, qb, 10);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_pkt(1, qc, qd, 0);
            end
            begin
                t = 0;
                forever begin
                    @(negedge clk);
                    if (req_ready[0] === 1'b1) break;
                    if (++t > 100) begin timeout_fail("t6_first_accept"); break; end
                end
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk);
                    check("t6_no_req1", 64'(req_ready[1]), 64'd0);
                    check("t6_busy", 64'(busy), 64'd1);
                end
            end
        join
        wait_drain();
        check("t6_count", 64'(id_log.size() - base), 64'd2);
        if (id_log.size() - base == 2) begin
            check("t6_first_id", 64'(id_log[base]), 64'd0);
            check("t6_first_data", data_log[base], 64'd500);
            check("t6_second_id", 64'(id_log[base+1]), 64'd1);
        end

        // Random packets from both requesters with random result back-pressure
        rand_done = 0;
        fork
            for (int r = 0; r < NREQ; r++) begin
                fork
                    automatic int rid = r;
                    begin
                        int unsigned ra[$], rb[$];
                        for (int p = 0; p < 6; p++) begin
                            ra.delete(); rb.delete();
                            for (int k = 0; k < $urandom_range(1, 5); k++) begin
                                ra.push_back($urandom_range(0, 255));
                                rb.push_back($urandom_range(0, 255));
                            end
                            send_pkt(rid, ra, rb, $urandom_range(0, 3));
                        end
                        rand_done++;
                    end
                join_none
            end
            begin
                t = 0;
                while (rand_done < NREQ && t < 20000) begin
                    @(posedge clk);
                    #1 res_ready = ($urandom_range(0, 3) != 0);
                    t++;
                end
                if (rand_done < NREQ) timeout_fail("rand_senders");
            end
        join
        @(posedge clk); #1 res_ready = 1'b1;
        wait_drain();
        check("rand_queues_empty", 64'(exp_data[0].size() + exp_data[1].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
